// File: rtl/riscv_isa_pkg.sv
// Shared RISC-V ISA definitions: trap FSM state encoding and machine cause codes.
package riscv_isa;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ENTER    = 2'd1,
    REDIRECT = 2'd2
  } trap_state_e;

  localparam int unsigned ILLEGAL_INST = 2;
  localparam int unsigned MTIMER_IRQ   = 7;
  localparam int unsigned ECALL_M      = 11;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/return sequencer: exception/irq -> ENTER (mepc/mcause strobe) -> REDIRECT, 2 cycles; MRET -> REDIRECT, 1 cycle.
// Redirect is held stable until fetch accepts it; busy stalls upstream commit for the whole sequence.
module trap_ctrl
  import riscv_isa::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic            exc_valid,
  input  logic [XLEN-2:0] exc_code,
  input  logic            mret_valid,
  input  logic            irq_req,
  input  logic [XLEN-2:0] irq_code,
  input  logic [XLEN-3:0] csr_rd_mtvec_base,
  input  logic [1:0]      csr_rd_mtvec_mode,
  input  logic [XLEN-1:0] csr_rd_mepc_mepc,
  output logic            ent_trap,
  output logic [XLEN-1:0] csr_wr_mepc_mepc,
  output logic [XLEN-2:0] csr_wr_mcause_exception_code,
  output logic            csr_wr_mcause_interrupt,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            busy
);

  trap_state_e     r_state;
  trap_state_e     w_nxt_state;

  logic [XLEN-1:0] r_epc;
  logic [XLEN-2:0] r_cause;
  logic            r_intr;
  logic [XLEN-1:0] r_redir_pc;

  logic            w_take_exc;
  logic            w_take_irq;
  logic            w_take_mret;
  logic [XLEN-1:0] w_base_addr;
  logic [XLEN-1:0] w_vec_off;
  logic [XLEN-1:0] w_trap_target;

  // Exceptions outrank interrupts, which outrank MRET; all gated by commit_valid.
  assign w_take_exc  = commit_valid & exc_valid;
  assign w_take_irq  = commit_valid & ~exc_valid & irq_req;
  assign w_take_mret = commit_valid & ~exc_valid & ~irq_req & mret_valid;

  assign w_base_addr   = {csr_rd_mtvec_base, 2'b00};
  assign w_vec_off     = {r_cause[XLEN-3:0], 2'b00};
  assign w_trap_target = ((csr_rd_mtvec_mode == 2'd1) && r_intr) ?
                         (w_base_addr + w_vec_off) : w_base_addr;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= IDLE;
    else        r_state <= w_nxt_state;
  end

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_take_exc || w_take_irq) w_nxt_state = ENTER;
        else if (w_take_mret)         w_nxt_state = REDIRECT;
      end
      ENTER:    w_nxt_state = REDIRECT;
      REDIRECT: if (redirect_ready) w_nxt_state = IDLE;
      default:  w_nxt_state = IDLE;
    endcase
  end

  // Capture registers only move in IDLE/ENTER, so redirect_pc is frozen in REDIRECT.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_epc      <= '0;
      r_cause    <= '0;
      r_intr     <= 1'b0;
      r_redir_pc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take_exc || w_take_irq) begin
            r_epc   <= commit_pc;
            r_cause <= w_take_exc ? exc_code : irq_code;
            r_intr  <= w_take_irq;
          end else if (w_take_mret) begin
            r_redir_pc <= csr_rd_mepc_mepc;
          end
        end
        ENTER:   r_redir_pc <= w_trap_target;
        default: ;
      endcase
    end
  end

  assign ent_trap                     = (r_state == ENTER);
  assign redirect_valid               = (r_state == REDIRECT);
  assign busy                         = (r_state != IDLE);
  assign redirect_pc                  = r_redir_pc;
  assign csr_wr_mepc_mepc             = r_epc;
  assign csr_wr_mcause_exception_code = r_cause;
  assign csr_wr_mcause_interrupt      = r_intr;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;
  import riscv_isa::*;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst_b;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            exc_valid;
  logic [XLEN-2:0] exc_code;
  logic            mret_valid;
  logic            irq_req;
  logic [XLEN-2:0] irq_code;
  logic [XLEN-3:0] csr_rd_mtvec_base;
  logic [1:0]      csr_rd_mtvec_mode;
  logic [XLEN-1:0] csr_rd_mepc_mepc;
  logic            ent_trap;
  logic [XLEN-1:0] csr_wr_mepc_mepc;
  logic [XLEN-2:0] csr_wr_mcause_exception_code;
  logic            csr_wr_mcause_interrupt;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk                          (clk),
    .rst_b                        (rst_b),
    .commit_valid                 (commit_valid),
    .commit_pc                    (commit_pc),
    .exc_valid                    (exc_valid),
    .exc_code                     (exc_code),
    .mret_valid                   (mret_valid),
    .irq_req                      (irq_req),
    .irq_code                     (irq_code),
    .csr_rd_mtvec_base            (csr_rd_mtvec_base),
    .csr_rd_mtvec_mode            (csr_rd_mtvec_mode),
    .csr_rd_mepc_mepc             (csr_rd_mepc_mepc),
    .ent_trap                     (ent_trap),
    .csr_wr_mepc_mepc             (csr_wr_mepc_mepc),
    .csr_wr_mcause_exception_code (csr_wr_mcause_exception_code),
    .csr_wr_mcause_interrupt      (csr_wr_mcause_interrupt),
    .redirect_valid               (redirect_valid),
    .redirect_pc                  (redirect_pc),
    .redirect_ready               (redirect_ready),
    .busy                         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_commit();
    commit_valid = 1'b0;
    exc_valid    = 1'b0;
    irq_req      = 1'b0;
    mret_valid   = 1'b0;
  endtask

  initial begin
    rst_b             = 1'b0;
    clr_commit();
    commit_pc         = '0;
    exc_code          = '0;
    irq_code          = '0;
    csr_rd_mtvec_base = '0;
    csr_rd_mtvec_mode = 2'd0;
    csr_rd_mepc_mepc  = '0;
    redirect_ready    = 1'b1;

    tick();
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_ent",   64'(ent_trap), 64'd0);
    chk("rst_rv",    64'(redirect_valid), 64'd0);
    chk("rst_rpc",   64'(redirect_pc), 64'd0);
    chk("rst_mepc",  64'(csr_wr_mepc_mepc), 64'd0);
    chk("rst_cause", 64'(csr_wr_mcause_exception_code), 64'd0);
    chk("rst_int",   64'(csr_wr_mcause_interrupt), 64'd0);
    rst_b = 1'b1;
    tick();

    // Direct exception, mtvec 0x8000_0100 mode 0
    csr_rd_mtvec_base = 30'h2000_0040;
    csr_rd_mtvec_mode = 2'd0;
    commit_valid = 1'b1; exc_valid = 1'b1;
    commit_pc = 32'h8000_0040; exc_code = 31'(ECALL_M);
    tick();
    clr_commit();
    chk("exc_ent",   64'(ent_trap), 64'd1);
    chk("exc_mepc",  64'(csr_wr_mepc_mepc), 64'h8000_0040);
    chk("exc_cause", 64'(csr_wr_mcause_exception_code), 64'd11);
    chk("exc_int",   64'(csr_wr_mcause_interrupt), 64'd0);
    chk("exc_rv_n1", 64'(redirect_valid), 64'd0);
    chk("exc_busy",  64'(busy), 64'd1);
    tick();
    chk("exc_ent_n2", 64'(ent_trap), 64'd0);
    chk("exc_rv",     64'(redirect_valid), 64'd1);
    chk("exc_rpc",    64'(redirect_pc), 64'h8000_0100);
    tick();
    chk("exc_rv_done",   64'(redirect_valid), 64'd0);
    chk("exc_busy_done", 64'(busy), 64'd0);

    // Vectored interrupt, base 0x8000_0000 mode 1, code 7
    csr_rd_mtvec_base = 30'h2000_0000;
    csr_rd_mtvec_mode = 2'd1;
    commit_valid = 1'b1; irq_req = 1'b1;
    commit_pc = 32'h8000_0200; irq_code = 31'(MTIMER_IRQ);
    tick();
    clr_commit();
    chk("irq_ent",   64'(ent_trap), 64'd1);
    chk("irq_int",   64'(csr_wr_mcause_interrupt), 64'd1);
    chk("irq_cause", 64'(csr_wr_mcause_exception_code), 64'd7);
    chk("irq_mepc",  64'(csr_wr_mepc_mepc), 64'h8000_0200);
    tick();
    chk("irq_rpc", 64'(redirect_pc), 64'h8000_001C);
    tick();
    chk("irq_idle", 64'(busy), 64'd0);

    // Simultaneous exc/irq/mret: exception wins, direct target despite mode 1
    commit_valid = 1'b1; exc_valid = 1'b1; irq_req = 1'b1; mret_valid = 1'b1;
    commit_pc = 32'h8000_0300; exc_code = 31'(ILLEGAL_INST); irq_code = 31'd7;
    csr_rd_mepc_mepc = 32'h1234_5678;
    tick();
    clr_commit();
    chk("pri_ent",   64'(ent_trap), 64'd1);
    chk("pri_cause", 64'(csr_wr_mcause_exception_code), 64'd2);
    chk("pri_int",   64'(csr_wr_mcause_interrupt), 64'd0);
    chk("pri_rv_n1", 64'(redirect_valid), 64'd0);
    tick();
    chk("pri_rpc", 64'(redirect_pc), 64'h8000_0000);
    tick();

    // MRET with backpressure; exc request while busy must be ignored
    csr_rd_mepc_mepc = 32'h8000_0044;
    redirect_ready = 1'b0;
    commit_valid = 1'b1; mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    exc_valid = 1'b1; exc_code = 31'd11;
    csr_rd_mepc_mepc = 32'hDEAD_BEEC;
    chk("mret_rv",  64'(redirect_valid), 64'd1);
    chk("mret_rpc", 64'(redirect_pc), 64'h8000_0044);
    chk("mret_ent", 64'(ent_trap), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mret_hold_rv",  64'(redirect_valid), 64'd1);
      chk("mret_hold_rpc", 64'(redirect_pc), 64'h8000_0044);
      chk("mret_hold_ent", 64'(ent_trap), 64'd0);
    end
    clr_commit();
    redirect_ready = 1'b1;
    tick();
    chk("mret_idle",   64'(busy), 64'd0);
    chk("mret_no_ent", 64'(ent_trap), 64'd0);

    // Wrap-around: base 0xFFFF_FFFC mode 1, irq code 3
    csr_rd_mtvec_base = 30'h3FFF_FFFF;
    commit_valid = 1'b1; irq_req = 1'b1; irq_code = 31'd3;
    commit_pc = 32'h0000_1000;
    tick();
    clr_commit();
    tick();
    chk("wrap_rpc", 64'(redirect_pc), 64'h0000_0008);
    tick();

    // Reset mid-REDIRECT, then a normal exception
    csr_rd_mtvec_base = 30'h2000_0040;
    csr_rd_mtvec_mode = 2'd0;
    redirect_ready = 1'b0;
    commit_valid = 1'b1; exc_valid = 1'b1;
    commit_pc = 32'h8000_0500; exc_code = 31'd11;
    tick();
    clr_commit();
    tick();
    chk("rr_rv_pre", 64'(redirect_valid), 64'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("rr_busy", 64'(busy), 64'd0);
    chk("rr_rv",   64'(redirect_valid), 64'd0);
    chk("rr_rpc",  64'(redirect_pc), 64'd0);
    #2;
    rst_b = 1'b1;
    redirect_ready = 1'b1;
    tick();
    chk("rr_still_idle", 64'(busy), 64'd0);
    commit_valid = 1'b1; exc_valid = 1'b1;
    commit_pc = 32'h8000_0600; exc_code = 31'd2;
    tick();
    clr_commit();
    chk("post_ent",  64'(ent_trap), 64'd1);
    chk("post_mepc", 64'(csr_wr_mepc_mepc), 64'h8000_0600);
    tick();
    chk("post_rpc", 64'(redirect_pc), 64'h8000_0100);
    tick();
    chk("post_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
